mode_counter: RTL and testbench

Parametrised up/down counter that succeeds the single-mode wrap counter. Adds a runtime limit, direction control, synchronous clear/load, and three terminal modes: wrap, saturate, one-shot. Used as a generic timebase and event counter in the digital datapath. The loop output remains a wrap-event pulse.

---
 rtl/mode_counter.sv | 124 ++++++++++++
 tb/tb_mode_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
// Module   : mode_counter
// Purpose  : Up/down counter with runtime limit and wrap/saturate/one-shot
//            terminal modes. Optional wrap-event counter under LOOP_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mode_counter #(
    parameter int WIDTH  = 4,
    parameter int LOOP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              dir,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  limit,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  count,
    output logic              loop,
    output logic              at_term,
    output logic              done
`ifdef LOOP_COUNT_EN
    ,
    output logic [LOOP_W-1:0] loop_cnt
`endif
);

    localparam logic [1:0] c_MODE_SAT     = 2'b01;
    localparam logic [1:0] c_MODE_ONESHOT = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_nxt;
    logic               r_loop;
    logic               w_loop_nxt;
    logic               w_above;

    if (LOOP_W < 1) begin : g_bad_loop_w
        $error("mode_counter: LOOP_W must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_loop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_loop  <= w_loop_nxt;
        end
    end

    assign at_term = dir ? (r_count == '0) : (r_count == limit);
    // A limit lowered under the current count behaves as a terminal hit.
    assign w_above = (r_count > limit);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_loop_nxt  = 1'b0;
        if (clr) begin
            w_count_nxt = dir ? limit : '0;
            w_state_nxt = ST_RUN;
        end else if (load) begin
            w_count_nxt = (load_val > limit) ? limit : load_val;
            w_state_nxt = ST_RUN;
        end else if (en && (r_state == ST_RUN)) begin
            if (dir && w_above) begin
                w_count_nxt = limit;
            end else if (w_above || at_term) begin
                case (mode)
                    c_MODE_SAT: begin
                        w_count_nxt = dir ? '0 : limit;
                    end
                    c_MODE_ONESHOT: begin
                        w_count_nxt = dir ? '0 : limit;
                        w_state_nxt = ST_DONE;
                    end
                    default: begin
                        // Wrap, including the reserved encoding.
                        w_count_nxt = dir ? limit : '0;
                        w_loop_nxt  = 1'b1;
                    end
                endcase
            end else if (dir) begin
                w_count_nxt = r_count - WIDTH'(1);
            end else begin
                w_count_nxt = r_count + WIDTH'(1);
            end
        end
    end

    assign count = r_count;
    assign loop  = r_loop;
    assign done  = (r_state == ST_DONE);

`ifdef LOOP_COUNT_EN
    logic [LOOP_W-1:0] r_loop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loop_cnt <= '0;
        end else if (clr) begin
            r_loop_cnt <= '0;
        end else if (r_loop && (r_loop_cnt != '1)) begin
            r_loop_cnt <= r_loop_cnt + LOOP_W'(1);
        end
    end

    assign loop_cnt = r_loop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mode_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mode_counter
// Purpose  : Scoreboard bench for mode_counter with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, dir, clr, load;
    logic [3:0] load_val, limit;
    logic [1:0] mode;
    logic [3:0] count;
    logic       loop, at_term, done;
`ifdef LOOP_COUNT_EN
    logic [1:0] loop_cnt;
`endif

    typedef struct packed {
        logic [3:0] cnt;
        logic       lp;
        logic       dn;
        logic       term;
        logic       lc_valid;
        logic [1:0] lc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(4), .LOOP_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .mode     (mode),
        .count    (count),
        .loop     (loop),
        .at_term  (at_term),
        .done     (done)
`ifdef LOOP_COUNT_EN
        ,
        .loop_cnt (loop_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Apply one cycle of inputs and queue the response expected after the next edge.
    task automatic drive(input logic i_en, input logic i_dir, input logic i_clr,
                         input logic i_load, input logic [3:0] i_lv,
                         input logic [3:0] i_lim, input logic [1:0] i_mode,
                         input logic [3:0] e_cnt, input logic e_loop,
                         input logic e_done, input logic e_term,
                         input logic e_lcv, input logic [1:0] e_lc);
        exp_t e;
        @(negedge clk);
        en = i_en; dir = i_dir; clr = i_clr; load = i_load;
        load_val = i_lv; limit = i_lim; mode = i_mode;
        e.cnt = e_cnt; e.lp = e_loop; e.dn = e_done; e.term = e_term;
        e.lc_valid = e_lcv; e.lc = e_lc;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("count", int'(count), int'(mon_e.cnt));
            chk("loop", int'(loop), int'(mon_e.lp));
            chk("done", int'(done), int'(mon_e.dn));
            chk("at_term", int'(at_term), int'(mon_e.term));
`ifdef LOOP_COUNT_EN
            if (mon_e.lc_valid) chk("loop_cnt", int'(loop_cnt), int'(mon_e.lc));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 0; dir = 0; clr = 0; load = 0;
        load_val = 0; limit = 0; mode = 0;
        #3;
        chk("reset_count", int'(count), 0);
        chk("reset_loop", int'(loop), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_at_term_lim0", int'(at_term), 1);
        #4 rst_n = 1'b1;

        // Wrap up through limit 15
        drive(0, 0, 1, 0, 0, 15, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++)
            drive(1, 0, 0, 0, 0, 15, 2'b00, 4'(i % 16), (i == 16), 0, ((i % 16) == 15), 0, 0);

        // Saturate at 9, then count down
        drive(0, 0, 1, 0, 0, 9, 2'b01, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 14; i++)
            drive(1, 0, 0, 0, 0, 9, 2'b01, 4'((i < 9) ? i : 9), 0, 0, (i >= 9), 0, 0);
        for (int i = 1; i <= 3; i++)
            drive(1, 1, 0, 0, 0, 9, 2'b01, 4'(9 - i), 0, 0, 0, 0, 0);

        // One-shot down from loaded 3
        drive(0, 1, 0, 1, 3, 5, 2'b10, 3, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++)
            drive(1, 1, 0, 0, 3, 5, 2'b10, 4'((i < 3) ? 3 - i : 0), 0, (i >= 4), (i >= 3), 0, 0);
        drive(0, 1, 1, 0, 3, 5, 2'b10, 5, 0, 0, 0, 0, 0);

        // clr beats load; load clamps to limit
        drive(0, 0, 1, 1, 12, 7, 2'b00, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 12, 7, 2'b00, 7, 0, 0, 1, 0, 0);

        // Asynchronous reset mid-count
        drive(0, 0, 1, 0, 0, 15, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++)
            drive(1, 0, 0, 0, 0, 15, 2'b00, 4'(i), 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_loop", int'(loop), 0);
        chk("async_rst_done", int'(done), 0);
        #1 rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 15, 2'b00, 1, 0, 0, 0, 0, 0);

        // Runtime limit lowered below count
        drive(0, 0, 0, 1, 10, 15, 2'b01, 10, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 10, 4, 2'b01, 4, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 10, 15, 2'b00, 10, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 10, 4, 2'b00, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 10, 15, 2'b00, 10, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 10, 4, 2'b00, 4, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 10, 4, 2'b00, 4, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 4, 2'b00, 0, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 4, 2'b00, 4, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0);
        // Reserved mode wraps
        drive(0, 0, 0, 1, 4, 4, 2'b11, 4, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 4, 4, 2'b11, 0, 1, 0, 0, 0, 0);
        // One-shot up with lowered limit; load leaves DONE
        drive(0, 0, 0, 1, 10, 15, 2'b10, 10, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 10, 4, 2'b10, 4, 0, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 10, 4, 2'b10, 4, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 2, 15, 2'b10, 2, 0, 0, 0, 0, 0);

`ifdef LOOP_COUNT_EN
        drive(0, 0, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 12; i++)
            drive(1, 0, 0, 0, 0, 1, 2'b00, 4'(i % 2), ((i % 2) == 0), 0, ((i % 2) == 1),
                  1, 2'(((i - 1) / 2 > 3) ? 3 : (i - 1) / 2));
        drive(0, 0, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0);
`endif

        @(negedge clk);
        en = 0; clr = 0; load = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
